// File: rtl/mfp_ahb_interconnect.sv
// mfp_ahb_interconnect
//   AHB-lite interconnect: one master (MIPSfpga core) to N_SLAVES slaves.
//   Address phase: mask/match decode, lowest-index hit drives HSEL_S.
//   Data phase: registered select (dsel) routes HRDATA/HREADY/HRESP back
//   from the owning slave, so slaves may stretch a transfer via HREADYOUT.
//   Transfers that hit no slave go to an internal default slave that returns
//   a two-cycle ERROR response and logs the faulting address and a count.
//
// Ports
//   HCLK, HRESETn        bus clock, synchronous active-low reset
//   HADDR/HTRANS/HWRITE  master address-phase signals
//   HRDATA/HREADY/HRESP  data-phase response to the master (HREADY also
//                        fans out to every slave)
//   HSEL_S               one-hot (or zero) address-phase slave select
//   HRDATA_S, HREADYOUT_S, HRESP_S
//                        per-slave responses, slice i belongs to slave i
//   ERR_ADDR, ERR_CNT    last unmapped address / saturating unmapped count
module mfp_ahb_interconnect #(
   parameter int N_SLAVES = 5,
   parameter logic [32*N_SLAVES-1:0] ADDR_MASK =
      {32'hffc00000, 32'hffc00000, 32'hffc00000, 32'hf0000000, 32'hffc00000},
   parameter logic [32*N_SLAVES-1:0] ADDR_MATCH =
      {32'hbf000000, 32'hbf400000, 32'hbf800000, 32'h80000000, 32'hbfc00000},
   parameter int ERR_CNT_W = 16
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic [31:0]             HADDR,
   input  logic [1:0]              HTRANS,
   input  logic                    HWRITE,
   output logic [31:0]             HRDATA,
   output logic                    HREADY,
   output logic                    HRESP,
   output logic [N_SLAVES-1:0]     HSEL_S,
   input  logic [32*N_SLAVES-1:0]  HRDATA_S,
   input  logic [N_SLAVES-1:0]     HREADYOUT_S,
   input  logic [N_SLAVES-1:0]     HRESP_S,
   output logic [31:0]             ERR_ADDR,
   output logic [ERR_CNT_W-1:0]    ERR_CNT
);

   typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

   logic [N_SLAVES-1:0] hit;
   logic [N_SLAVES-1:0] hsel;
   logic                unmapped;
   logic                take_err;
   logic [N_SLAVES:0]   dsel;      // bit N_SLAVES = default (error) slave
   ds_state_t           ds_state;
   logic                ds_hready;
   logic                ds_hresp;

   // Write direction and the SEQ/NONSEQ distinction do not affect routing.
   logic unused_ok;
   assign unused_ok = &{1'b0, HTRANS[0], HWRITE};

   // Address decode
   genvar gi;
   generate
      for (gi = 0; gi < N_SLAVES; gi++) begin : g_dec
         assign hit[gi] = (HADDR & ADDR_MASK[32*gi +: 32]) == ADDR_MATCH[32*gi +: 32];
      end
   endgenerate

   // Overlapping windows resolve to the lowest index: scan downwards so the
   // last assignment is the lowest hit.
   always_comb begin
      hsel = '0;
      for (int i = N_SLAVES-1; i >= 0; i--)
         if (hit[i]) hsel = N_SLAVES'(1) << i;
   end

   assign HSEL_S   = hsel;
   assign unmapped = HTRANS[1] && (hit == '0);
   assign take_err = HREADY && unmapped;

   // Data-phase response mux; dsel is one-hot or zero
   always_comb begin
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (dsel[N_SLAVES]) begin
         HREADY = ds_hready;
         HRESP  = ds_hresp;
      end
      for (int i = 0; i < N_SLAVES; i++) begin
         if (dsel[i]) begin
            HRDATA = HRDATA_S[32*i +: 32];
            HREADY = HREADYOUT_S[i];
            HRESP  = HRESP_S[i];
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         dsel      <= '0;
         ds_state  <= DS_IDLE;
         ds_hready <= 1'b1;
         ds_hresp  <= 1'b0;
         ERR_ADDR  <= '0;
         ERR_CNT   <= '0;
      end else begin
         // Only a completed data phase hands the bus to the next owner.
         if (HREADY)
            dsel <= {unmapped, hsel};

         if (take_err) begin
            ERR_ADDR <= HADDR;
            if (ERR_CNT != '1)
               ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
         end

         // Default slave: ERROR takes two cycles (first with HREADY low) so
         // the master can cancel its pipelined next address.
         case (ds_state)
            DS_IDLE: begin
               if (take_err) begin
                  ds_state  <= DS_ERR1;
                  ds_hready <= 1'b0;
                  ds_hresp  <= 1'b1;
               end
            end
            DS_ERR1: begin
               ds_state  <= DS_ERR2;
               ds_hready <= 1'b1;
               ds_hresp  <= 1'b1;
            end
            DS_ERR2: begin
               if (take_err) begin
                  ds_state  <= DS_ERR1;
                  ds_hready <= 1'b0;
                  ds_hresp  <= 1'b1;
               end else begin
                  ds_state  <= DS_IDLE;
                  ds_hready <= 1'b1;
                  ds_hresp  <= 1'b0;
               end
            end
            default: begin
               ds_state  <= DS_IDLE;
               ds_hready <= 1'b1;
               ds_hresp  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
module tb_mfp_ahb_interconnect;

   localparam int NS = 5;

   logic          HCLK;
   logic          HRESETn;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [31:0]   HRDATA;
   logic          HREADY;
   logic          HRESP;
   logic [NS-1:0] HSEL_S;
   logic [32*NS-1:0] HRDATA_S;
   logic [NS-1:0] HREADYOUT_S;
   logic [NS-1:0] HRESP_S;
   logic [31:0]   ERR_ADDR;
   logic [15:0]   ERR_CNT;

   // Second instance: overlapping windows and a narrow counter
   logic [31:0]   s_haddr;
   logic [1:0]    s_htrans;
   logic [31:0]   s_hrdata;
   logic          s_hready;
   logic          s_hresp;
   logic [3:0]    s_hsel;
   logic [31:0]   s_err_addr;
   logic [3:0]    s_err_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   mfp_ahb_interconnect dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
      .HSEL_S(HSEL_S), .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S),
      .HRESP_S(HRESP_S), .ERR_ADDR(ERR_ADDR), .ERR_CNT(ERR_CNT)
   );

   mfp_ahb_interconnect #(
      .N_SLAVES(4),
      .ADDR_MASK ({32'hf0000000, 32'hffff0000, 32'hffff0000, 32'hff000000}),
      .ADDR_MATCH({32'h10000000, 32'h20000000, 32'h30000000, 32'h10000000}),
      .ERR_CNT_W(4)
   ) u_small (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(s_haddr), .HTRANS(s_htrans),
      .HWRITE(1'b0), .HRDATA(s_hrdata), .HREADY(s_hready), .HRESP(s_hresp),
      .HSEL_S(s_hsel), .HRDATA_S(128'h0), .HREADYOUT_S(4'hf),
      .HRESP_S(4'h0), .ERR_ADDR(s_err_addr), .ERR_CNT(s_err_cnt)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // ---------------- reference model ----------------
   // Decode straight from the address map, slaves in priority order.
   function automatic int first_hit(input logic [31:0] a);
      if (a[31:22] == 10'h2ff) return 0;           // 0xbfc00000
      if (a[31:28] == 4'h8)    return 1;           // 0x80000000
      if (a[31:22] == 10'h2fe) return 2;           // 0xbf800000
      if (a[31:22] == 10'h2fd) return 3;           // 0xbf400000
      if (a[31:22] == 10'h2fc) return 4;           // 0xbf000000
      return -1;
   endfunction

   int          m_owner;   // -1 none, 0..NS-1 slave, NS error responder
   int          m_phase;   // which cycle of the error response (1 or 2)
   int          m_cnt;
   logic [31:0] m_addr;
   logic [31:0] e_rdata;
   logic        e_ready;
   logic        e_resp;

   task automatic model_reset();
      m_owner = -1; m_phase = 0; m_cnt = 0; m_addr = '0;
   endtask

   task automatic model_predict();
      e_rdata = '0; e_ready = 1'b1; e_resp = 1'b0;
      if (m_owner == NS) begin
         e_ready = (m_phase == 2);
         e_resp  = 1'b1;
      end else if (m_owner >= 0) begin
         e_rdata = HRDATA_S[32*m_owner +: 32];
         e_ready = HREADYOUT_S[m_owner];
         e_resp  = HRESP_S[m_owner];
      end
   endtask

   task automatic model_step(input logic rst, input logic [31:0] a,
                             input logic [1:0] tr, input logic r);
      int h;
      if (rst) begin
         model_reset();
      end else if (r) begin
         h = first_hit(a);
         if (tr[1] && h < 0) begin
            m_owner = NS; m_phase = 1; m_addr = a;
            if (m_cnt < 65535) m_cnt++;
         end else begin
            m_owner = h;
         end
      end else if (m_owner == NS && m_phase == 1) begin
         m_phase = 2;
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] off;
      off = $urandom & 32'h003fffff;
      case ($urandom_range(0, 5))
         0: return 32'hbfc00000 | off;
         1: return 32'h80000000 | ($urandom & 32'h0fffffff);
         2: return 32'hbf800000 | off;
         3: return 32'hbf400000 | off;
         4: return 32'hbf000000 | off;
         default: return 32'h40000000 | ($urandom & 32'h0fffffff);
      endcase
   endfunction

   // ---------------- decode table ----------------
   typedef struct {
      logic [31:0]   addr;
      logic [NS-1:0] hsel;
   } dec_vec_t;
   dec_vec_t tbl[12];

   initial begin
      int h;
      logic [NS-1:0] ehsel;

      tbl[0]  = '{32'h80000010, 5'b00010};
      tbl[1]  = '{32'h8fffffff, 5'b00010};
      tbl[2]  = '{32'hbfc00000, 5'b00001};
      tbl[3]  = '{32'hbfffffff, 5'b00001};
      tbl[4]  = '{32'hbf800004, 5'b00100};
      tbl[5]  = '{32'hbfbfffff, 5'b00100};
      tbl[6]  = '{32'hbf400000, 5'b01000};
      tbl[7]  = '{32'hbf7fffff, 5'b01000};
      tbl[8]  = '{32'hbf3fffff, 5'b10000};
      tbl[9]  = '{32'h90000000, 5'b00000};
      tbl[10] = '{32'h00001000, 5'b00000};
      tbl[11] = '{32'h7fffffff, 5'b00000};

      HRESETn = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
      HRDATA_S = '0; HREADYOUT_S = '1; HRESP_S = '0;
      s_haddr = '0; s_htrans = 2'b00;
      cyc(); cyc();
      settle();
      chk("rst_hready", 32'(HREADY), 32'd1);
      chk("rst_hresp", 32'(HRESP), 32'd0);
      chk("rst_hrdata", HRDATA, 32'h0);
      chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
      chk("rst_err_addr", ERR_ADDR, 32'h0);
      HRESETn = 1'b1;
      cyc();

      // Decode table (IDLE so nothing is logged)
      for (int i = 0; i < 12; i++) begin
         HADDR = tbl[i].addr; HTRANS = 2'b00;
         settle();
         chk($sformatf("decode[%0d]", i), 32'(HSEL_S), 32'(tbl[i].hsel));
         cyc();
      end
      HADDR = '0;
      cyc();

      // Simple read from slave1
      HRDATA_S[32*1 +: 32] = 32'h12345678;
      HADDR = 32'h80000010; HTRANS = 2'b10;
      settle();
      chk("rd1_hsel", 32'(HSEL_S), 32'b00010);
      cyc();
      HADDR = '0; HTRANS = 2'b00;
      settle();
      chk("rd1_hrdata", HRDATA, 32'h12345678);
      chk("rd1_hready", 32'(HREADY), 32'd1);
      chk("rd1_hresp", 32'(HRESP), 32'd0);
      cyc();

      // Slave2 wait states while next address targets slave0
      HADDR = 32'hbf800004; HTRANS = 2'b10;
      settle();
      chk("ws_hsel_a", 32'(HSEL_S), 32'b00100);
      cyc();
      HADDR = 32'hbfc00000; HTRANS = 2'b10;
      HREADYOUT_S[2] = 1'b0;
      HRDATA_S[32*2 +: 32] = 32'h22222222;
      HRDATA_S[32*0 +: 32] = 32'hcafe0000;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) cyc();
         settle();
         chk($sformatf("ws_hready_low[%0d]", k), 32'(HREADY), 32'd0);
         chk($sformatf("ws_hrdata_hold[%0d]", k), HRDATA, 32'h22222222);
      end
      cyc();
      HREADYOUT_S[2] = 1'b1;
      settle();
      chk("ws_hready_end", 32'(HREADY), 32'd1);
      chk("ws_hrdata_end", HRDATA, 32'h22222222);
      cyc();
      HADDR = '0; HTRANS = 2'b00;
      settle();
      chk("ws_next_hrdata", HRDATA, 32'hcafe0000);
      chk("ws_next_hready", 32'(HREADY), 32'd1);
      cyc();

      // Single unmapped transfer
      HADDR = 32'h00001000; HTRANS = 2'b10;
      cyc();
      HADDR = '0; HTRANS = 2'b00;
      settle();
      chk("err_e1_hready", 32'(HREADY), 32'd0);
      chk("err_e1_hresp", 32'(HRESP), 32'd1);
      cyc();
      settle();
      chk("err_e2_hready", 32'(HREADY), 32'd1);
      chk("err_e2_hresp", 32'(HRESP), 32'd1);
      chk("err_addr", ERR_ADDR, 32'h00001000);
      chk("err_cnt1", 32'(ERR_CNT), 32'd1);
      cyc();
      settle();
      chk("err_done_hready", 32'(HREADY), 32'd1);
      chk("err_done_hresp", 32'(HRESP), 32'd0);

      // Back-to-back unmapped, second issued in ERR2
      HADDR = 32'h00002000; HTRANS = 2'b10;
      cyc();
      HADDR = '0; HTRANS = 2'b00;
      settle();
      chk("b2b_e1a", 32'({HREADY, HRESP}), 32'b01);
      cyc();
      HADDR = 32'h00003000; HTRANS = 2'b10;
      settle();
      chk("b2b_e2a", 32'({HREADY, HRESP}), 32'b11);
      cyc();
      HADDR = '0; HTRANS = 2'b00;
      settle();
      chk("b2b_e1b", 32'({HREADY, HRESP}), 32'b01);
      cyc();
      HADDR = 32'h00003000; HTRANS = 2'b00;   // IDLE to unmapped: harmless
      settle();
      chk("b2b_e2b", 32'({HREADY, HRESP}), 32'b11);
      chk("b2b_cnt", 32'(ERR_CNT), 32'd3);
      chk("b2b_addr", ERR_ADDR, 32'h00003000);
      cyc();
      settle();
      chk("idle_unm_resp", 32'({HREADY, HRESP}), 32'b10);
      cyc();
      settle();
      chk("idle_unm_resp2", 32'({HREADY, HRESP}), 32'b10);
      chk("idle_unm_cnt", 32'(ERR_CNT), 32'd3);

      // Reset in the middle of ERR1
      HADDR = 32'h00004000; HTRANS = 2'b10;
      cyc();
      HADDR = '0; HTRANS = 2'b00;
      settle();
      chk("rst_e1_pre", 32'({HREADY, HRESP}), 32'b01);
      HRESETn = 1'b0;
      cyc();
      settle();
      chk("rst_e1_hready", 32'(HREADY), 32'd1);
      chk("rst_e1_hresp", 32'(HRESP), 32'd0);
      chk("rst_e1_cnt", 32'(ERR_CNT), 32'd0);
      chk("rst_e1_addr", ERR_ADDR, 32'h0);
      HRESETn = 1'b1;
      cyc();

      // Overlapping windows and counter saturation on the small instance
      s_haddr = 32'h10000040; s_htrans = 2'b10;
      settle();
      chk("ovl_hsel_both", 32'(s_hsel), 32'b0001);
      s_haddr = 32'h15000000;
      settle();
      chk("ovl_hsel_only3", 32'(s_hsel), 32'b1000);
      s_htrans = 2'b00;
      cyc();
      for (int k = 1; k <= 17; k++) begin
         s_haddr = 32'h00000000 + 32'(k); s_htrans = 2'b10;
         cyc();
         s_htrans = 2'b00;
         cyc();
         if (k == 14) begin
            settle();
            chk("sat_cnt14", 32'(s_err_cnt), 32'd14);
         end
         if (k == 15) begin
            settle();
            chk("sat_cnt15", 32'(s_err_cnt), 32'd15);
         end
      end
      settle();
      chk("sat_cnt_hold", 32'(s_err_cnt), 32'd15);
      chk("sat_addr", s_err_addr, 32'd17);
      cyc();

      // Randomised run against the reference model
      HRESETn = 1'b0;
      cyc();
      HRESETn = 1'b1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         logic rst;
         rst = ($urandom_range(0, 149) == 0);
         HRESETn = !rst;
         HADDR  = rand_addr();
         HTRANS = 2'($urandom_range(0, 3));
         HWRITE = 1'($urandom_range(0, 1));
         for (int k = 0; k < NS; k++) begin
            HRDATA_S[32*k +: 32] = $urandom;
            HREADYOUT_S[k] = ($urandom_range(0, 3) != 0);
            HRESP_S[k] = ($urandom_range(0, 7) == 0);
         end
         settle();
         model_predict();
         h = first_hit(HADDR);
         ehsel = (h >= 0) ? NS'(1) << h : '0;
         chk("rnd_hrdata", HRDATA, e_rdata);
         chk("rnd_hready", 32'(HREADY), 32'(e_ready));
         chk("rnd_hresp", 32'(HRESP), 32'(e_resp));
         chk("rnd_hsel", 32'(HSEL_S), 32'(ehsel));
         chk("rnd_err_cnt", 32'(ERR_CNT), 32'(m_cnt));
         chk("rnd_err_addr", ERR_ADDR, m_addr);
         @(posedge HCLK);
         model_step(rst, HADDR, HTRANS, e_ready);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
